// File: rtl/hazard_scoreboard.sv
// Forwarding/interlock scoreboard beside the ID stage: tracks in-flight GPR writers,
// selects the youngest forwarding source per operand and raises the load-use stall.
module hazard_scoreboard #(
  parameter int ADDR_W     = 5,
  parameter int DEPTH      = 3,
  parameter int NUM_SRC    = 2,
  parameter int LOAD_STAGE = 2,
  localparam int SEL_W     = $clog2(DEPTH + 1)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        hold,
  input  logic                        id_valid,
  input  logic                        id_wen,
  input  logic [ADDR_W-1:0]           id_waddr,
  input  logic                        id_is_load,
  input  logic [NUM_SRC*ADDR_W-1:0]   id_src_addr,
  input  logic [NUM_SRC-1:0]          id_src_used,
  input  logic                        id_flush,
  output logic [NUM_SRC*SEL_W-1:0]    fwd_sel,
  output logic                        stall,
  output logic [31:0]                 stall_cnt
);

  logic [DEPTH:1]    ent_v;
  logic [DEPTH:1]    ent_wen;
  logic [DEPTH:1]    ent_ld;
  logic [ADDR_W-1:0] ent_waddr [1:DEPTH];

  logic [NUM_SRC-1:0] hazard;
  logic [ADDR_W-1:0]  src;
  logic               capture;

  // Scan oldest to youngest so the youngest matching writer overwrites older ones.
  always_comb begin
    fwd_sel = '0;
    hazard  = '0;
    src     = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      src = id_src_addr[i*ADDR_W +: ADDR_W];
      for (int k = DEPTH; k >= 1; k--) begin
        if (ent_v[k] && ent_wen[k] && (ent_waddr[k] == src) &&
            id_src_used[i] && (src != '0)) begin
          fwd_sel[i*SEL_W +: SEL_W] = SEL_W'(k);
          hazard[i]                 = ent_ld[k] && (k < LOAD_STAGE);
        end
      end
    end
  end

  assign stall   = id_valid && !id_flush && (|hazard);
  assign capture = id_valid && !id_flush && !stall;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ent_v     <= '0;
      ent_wen   <= '0;
      ent_ld    <= '0;
      for (int k = 1; k <= DEPTH; k++) ent_waddr[k] <= '0;
      stall_cnt <= '0;
    end else if (!hold) begin
      for (int k = DEPTH; k >= 2; k--) begin
        ent_v[k]     <= ent_v[k-1];
        ent_wen[k]   <= ent_wen[k-1];
        ent_ld[k]    <= ent_ld[k-1];
        ent_waddr[k] <= ent_waddr[k-1];
      end
      // A stalled or squashed instruction leaves a bubble behind it.
      if (capture) begin
        ent_v[1]     <= 1'b1;
        ent_wen[1]   <= id_wen && (id_waddr != '0);
        ent_ld[1]    <= id_is_load;
        ent_waddr[1] <= id_waddr;
      end else begin
        ent_v[1]     <= 1'b0;
        ent_wen[1]   <= 1'b0;
        ent_ld[1]    <= 1'b0;
        ent_waddr[1] <= '0;
      end
      if (stall && (stall_cnt != 32'hFFFF_FFFF)) stall_cnt <= stall_cnt + 32'd1;
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: directed scenario tasks plus randomized traffic
// checked against a history-list model of the in-flight writers.
module tb_hazard_scoreboard;

  localparam int ADDR_W     = 5;
  localparam int DEPTH      = 3;
  localparam int NUM_SRC    = 2;
  localparam int LOAD_STAGE = 2;
  localparam int SEL_W      = 2;

  logic                      clk = 1'b0;
  logic                      rst;
  logic                      hold;
  logic                      id_valid;
  logic                      id_wen;
  logic [ADDR_W-1:0]         id_waddr;
  logic                      id_is_load;
  logic [NUM_SRC*ADDR_W-1:0] id_src_addr;
  logic [NUM_SRC-1:0]        id_src_used;
  logic                      id_flush;
  logic [NUM_SRC*SEL_W-1:0]  fwd_sel;
  logic                      stall;
  logic [31:0]               stall_cnt;

  hazard_scoreboard #(
    .ADDR_W(ADDR_W), .DEPTH(DEPTH), .NUM_SRC(NUM_SRC), .LOAD_STAGE(LOAD_STAGE)
  ) dut (
    .clk(clk), .rst(rst), .hold(hold), .id_valid(id_valid), .id_wen(id_wen),
    .id_waddr(id_waddr), .id_is_load(id_is_load), .id_src_addr(id_src_addr),
    .id_src_used(id_src_used), .id_flush(id_flush), .fwd_sel(fwd_sel),
    .stall(stall), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  wire [SEL_W-1:0] sel0 = fwd_sel[SEL_W-1:0];
  wire [SEL_W-1:0] sel1 = fwd_sel[2*SEL_W-1:SEL_W];

  int errors = 0;
  int checks = 0;

  // Model: list of what entered the pipeline on each of the last DEPTH un-held edges,
  // most recent first; position j corresponds to stage j+1.
  typedef struct packed {
    bit              v;
    bit              wen;
    bit [ADDR_W-1:0] waddr;
    bit              ld;
  } rec_t;

  rec_t        hist[$];
  bit   [31:0] m_cnt;

  function automatic void model_clear();
    hist.delete();
    for (int j = 0; j < DEPTH; j++) hist.push_back('0);
    m_cnt = 0;
  endfunction

  function automatic int model_sel(int i);
    bit [ADDR_W-1:0] s;
    s = id_src_addr[i*ADDR_W +: ADDR_W];
    if (!id_src_used[i] || s == 0) return 0;
    for (int j = 0; j < DEPTH; j++)
      if (hist[j].v && hist[j].wen && hist[j].waddr == s) return j + 1;
    return 0;
  endfunction

  function automatic bit model_stall();
    bit hz;
    int k;
    hz = 0;
    for (int i = 0; i < NUM_SRC; i++) begin
      k = model_sel(i);
      if (k != 0 && hist[k-1].ld && k < LOAD_STAGE) hz = 1;
    end
    return id_valid && !id_flush && hz;
  endfunction

  // One clock edge; inputs are sampled by both DUT and model at that edge.
  task automatic step();
    bit   s;
    rec_t r;
    s = model_stall();
    r = '0;
    if (id_valid && !id_flush && !s) begin
      r.v     = 1;
      r.wen   = id_wen && (id_waddr != 0);
      r.waddr = id_waddr;
      r.ld    = id_is_load;
    end
    @(posedge clk);
    if (!hold) begin
      hist.push_front(r);
      void'(hist.pop_back());
      if (s && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
    end
    #1;
  endtask

  task automatic set_idle();
    id_valid = 0; id_wen = 0; id_waddr = 0; id_is_load = 0;
    id_src_addr = 0; id_src_used = 0; id_flush = 0; hold = 0;
  endtask

  task automatic issue(input bit [ADDR_W-1:0] wa, input bit ld);
    set_idle();
    id_valid = 1; id_wen = 1; id_waddr = wa; id_is_load = ld;
    step();
  endtask

  task automatic drain();
    set_idle();
    repeat (DEPTH) step();
  endtask

  task automatic test_reset();
    issue(5'd5, 1'b1);
    set_idle();
    id_valid = 1; id_src_addr = {5'd0, 5'd5}; id_src_used = 2'b01;
    #1;
    checks++;
    if (stall !== 1'b1) begin errors++; $display("[TB] FAIL reset_pre_stall got %0b want 1", stall); end
    step();
    checks++;
    if (stall_cnt !== 32'd1) begin errors++; $display("[TB] FAIL reset_pre_cnt got %0d want 1", stall_cnt); end
    rst = 1;
    model_clear();
    #1;
    checks++;
    if (sel0 !== 2'd0) begin errors++; $display("[TB] FAIL reset_sel0 got %0d want 0", sel0); end
    checks++;
    if (stall !== 1'b0) begin errors++; $display("[TB] FAIL reset_stall got %0b want 0", stall); end
    checks++;
    if (stall_cnt !== 32'd0) begin errors++; $display("[TB] FAIL reset_cnt got %0d want 0", stall_cnt); end
    #2 rst = 0;
    set_idle();
    #1;
    checks++;
    if (fwd_sel !== '0) begin errors++; $display("[TB] FAIL reset_idle_sel got %0h want 0", fwd_sel); end
    step();
  endtask

  task automatic test_alu_chain();
    int want [3];
    want = '{2, 3, 0};
    issue(5'd3, 1'b0);
    set_idle();
    id_valid = 1; id_src_addr = {5'd0, 5'd3}; id_src_used = 2'b01;
    #1;
    checks++;
    if (sel0 !== 2'd1) begin errors++; $display("[TB] FAIL alu_sel_exe got %0d want 1", sel0); end
    checks++;
    if (stall !== 1'b0) begin errors++; $display("[TB] FAIL alu_stall got %0b want 0", stall); end
    step();
    id_valid = 0;
    for (int n = 0; n < 3; n++) begin
      #1;
      checks++;
      if (sel0 !== SEL_W'(want[n])) begin
        errors++; $display("[TB] FAIL alu_sel_age%0d got %0d want %0d", n + 2, sel0, want[n]);
      end
      step();
    end
    drain();
  endtask

  task automatic test_load_use();
    bit [31:0] c0;
    c0 = m_cnt;
    issue(5'd5, 1'b1);
    set_idle();
    id_valid = 1; id_src_addr = {5'd5, 5'd0}; id_src_used = 2'b10;
    #1;
    checks++;
    if (stall !== 1'b1) begin errors++; $display("[TB] FAIL lu_stall got %0b want 1", stall); end
    step();
    checks++;
    if (stall !== 1'b0) begin errors++; $display("[TB] FAIL lu_release got %0b want 0", stall); end
    checks++;
    if (sel1 !== 2'd2) begin errors++; $display("[TB] FAIL lu_sel1_mem got %0d want 2", sel1); end
    checks++;
    if (stall_cnt !== c0 + 32'd1) begin errors++; $display("[TB] FAIL lu_cnt got %0d want %0d", stall_cnt, c0 + 1); end
    step();
    drain();
  endtask

  task automatic test_r0_unused();
    issue(5'd0, 1'b0);
    set_idle();
    id_valid = 1; id_src_addr = {5'd0, 5'd0}; id_src_used = 2'b11;
    #1;
    checks++;
    if (sel0 !== 2'd0) begin errors++; $display("[TB] FAIL r0_sel0 got %0d want 0", sel0); end
    drain();
    issue(5'd6, 1'b0);
    set_idle();
    id_valid = 1; id_src_addr = {5'd6, 5'd6}; id_src_used = 2'b01;
    #1;
    checks++;
    if (sel1 !== 2'd0) begin errors++; $display("[TB] FAIL unused_sel1 got %0d want 0", sel1); end
    checks++;
    if (sel0 !== 2'd1) begin errors++; $display("[TB] FAIL used_sel0 got %0d want 1", sel0); end
    drain();
  endtask

  task automatic test_priority_flush();
    issue(5'd4, 1'b0);
    issue(5'd4, 1'b0);
    set_idle();
    id_valid = 1; id_src_addr = {5'd4, 5'd4}; id_src_used = 2'b11;
    #1;
    checks++;
    if (fwd_sel !== {2'd1, 2'd1}) begin errors++; $display("[TB] FAIL prio_sel got %0h want 5", fwd_sel); end
    drain();
    set_idle();
    id_valid = 1; id_wen = 1; id_waddr = 5'd7; id_is_load = 1; id_flush = 1;
    step();
    set_idle();
    id_valid = 1; id_src_addr = {5'd0, 5'd7}; id_src_used = 2'b01;
    #1;
    checks++;
    if (sel0 !== 2'd0) begin errors++; $display("[TB] FAIL flush_sel0 got %0d want 0", sel0); end
    checks++;
    if (stall !== 1'b0) begin errors++; $display("[TB] FAIL flush_stall got %0b want 0", stall); end
    drain();
    issue(5'd8, 1'b1);
    set_idle();
    id_valid = 1; id_flush = 1; id_src_addr = {5'd0, 5'd8}; id_src_used = 2'b01;
    #1;
    checks++;
    if (stall !== 1'b0) begin errors++; $display("[TB] FAIL flush_over_stall got %0b want 0", stall); end
    drain();
  endtask

  task automatic test_hold();
    bit [31:0] c0;
    issue(5'd9, 1'b1);
    c0 = m_cnt;
    set_idle();
    id_valid = 1; id_src_addr = {5'd0, 5'd9}; id_src_used = 2'b01;
    hold = 1;
    for (int n = 0; n < 3; n++) begin
      step();
      checks++;
      if (stall !== 1'b1 || sel0 !== 2'd1) begin
        errors++; $display("[TB] FAIL hold_frozen%0d got stall=%0b sel=%0d want stall=1 sel=1", n, stall, sel0);
      end
      checks++;
      if (stall_cnt !== c0) begin errors++; $display("[TB] FAIL hold_cnt%0d got %0d want %0d", n, stall_cnt, c0); end
    end
    hold = 0;
    step();
    checks++;
    if (stall_cnt !== c0 + 32'd1) begin errors++; $display("[TB] FAIL hold_release_cnt got %0d want %0d", stall_cnt, c0 + 1); end
    checks++;
    if (stall !== 1'b0 || sel0 !== 2'd2) begin
      errors++; $display("[TB] FAIL hold_release got stall=%0b sel=%0d want stall=0 sel=2", stall, sel0);
    end
    drain();
  endtask

  task automatic test_mid_reset();
    issue(5'd10, 1'b0);
    issue(5'd11, 1'b1);
    rst = 1;
    model_clear();
    #2 rst = 0;
    set_idle();
    id_valid = 1; id_src_addr = {5'd11, 5'd10}; id_src_used = 2'b11;
    #1;
    checks++;
    if (fwd_sel !== '0 || stall !== 1'b0) begin
      errors++; $display("[TB] FAIL midrst_clear got sel=%0h stall=%0b want 0/0", fwd_sel, stall);
    end
    issue(5'd10, 1'b0);
    set_idle();
    id_valid = 1; id_src_addr = {5'd0, 5'd10}; id_src_used = 2'b01;
    #1;
    checks++;
    if (sel0 !== 2'd1) begin errors++; $display("[TB] FAIL midrst_after got %0d want 1", sel0); end
    drain();
  endtask

  task automatic test_random();
    int e;
    for (int n = 0; n < 400; n++) begin
      id_valid    = ($urandom_range(0, 9) != 0);
      id_wen      = $urandom_range(0, 1);
      id_waddr    = ADDR_W'($urandom_range(0, 7));
      id_is_load  = ($urandom_range(0, 2) == 0);
      id_src_addr = {ADDR_W'($urandom_range(0, 7)), ADDR_W'($urandom_range(0, 7))};
      id_src_used = 2'($urandom_range(0, 3));
      id_flush    = ($urandom_range(0, 9) == 0);
      hold        = ($urandom_range(0, 9) == 0);
      #1;
      for (int i = 0; i < NUM_SRC; i++) begin
        e = model_sel(i);
        checks++;
        if (fwd_sel[i*SEL_W +: SEL_W] !== SEL_W'(e)) begin
          errors++; $display("[TB] FAIL rand_sel%0d cyc%0d got %0d want %0d", i, n, fwd_sel[i*SEL_W +: SEL_W], e);
        end
      end
      checks++;
      if (stall !== model_stall()) begin
        errors++; $display("[TB] FAIL rand_stall cyc%0d got %0b want %0b", n, stall, model_stall());
      end
      checks++;
      if (stall_cnt !== m_cnt) begin
        errors++; $display("[TB] FAIL rand_cnt cyc%0d got %0d want %0d", n, stall_cnt, m_cnt);
      end
      step();
    end
    drain();
  endtask

  initial begin
    set_idle();
    rst = 1;
    model_clear();
    repeat (2) @(posedge clk);
    #1 rst = 0;
    test_reset();
    test_alu_chain();
    test_load_use();
    test_r0_unused();
    test_priority_flush();
    test_hold();
    test_mid_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
